// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for two producers sharing one FIFO write port.
// A fixed-length burst is granted only when the FIFO has room; words pass through one register stage.
module fifo_wr_arbiter #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned SLACK     = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [1:0]        req,
  input  logic [1:0]        vld,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  output logic [1:0]        gnt,
  output logic [1:0]        rdy,
  output logic              burst_done,
  input  logic [CNT_W-1:0]  wr_data_count,
  input  logic              almost_full,
  input  logic              full,
  input  logic              wr_rst_busy,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_wr_data,
  output logic              ovf_err
);

  localparam int unsigned RemW = $clog2(BURST_LEN + 1);
  // Widened by one bit so the fill-level compare can never wrap.
  localparam logic [CNT_W:0] RoomMax = (CNT_W + 1)'(DEPTH - BURST_LEN - SLACK);

  typedef enum logic [1:0] {StIdle, StBurst, StDone} state_e;

  state_e            state_q;
  logic [1:0]        gnt_q;
  logic              last_q;
  logic [RemW-1:0]   remaining_q;
  logic              fifo_wr_en_q;
  logic [DATA_W-1:0] fifo_wr_data_q;
  logic              ovf_err_q;

  logic              room;
  logic              pick;
  logic              accept;
  logic              flow_ok;
  logic [DATA_W-1:0] win_data;

  always_comb begin
    room     = ~wr_rst_busy & ({1'b0, wr_data_count} <= RoomMax);
    pick     = ~last_q;
    if (req == 2'b01) pick = 1'b0;
    if (req == 2'b10) pick = 1'b1;
    flow_ok  = (state_q == StBurst) & ~almost_full & ~wr_rst_busy & ~sys_rst;
    rdy      = gnt_q & {2{flow_ok}};
    accept   = |(vld & rdy);
    win_data = gnt_q[1] ? data1 : data0;
  end

  // Outputs are masked during reset so nothing is asserted before the reset edge lands.
  assign gnt          = gnt_q & {2{~sys_rst}};
  assign burst_done   = (state_q == StDone) & ~sys_rst;
  assign fifo_wr_en   = fifo_wr_en_q & ~sys_rst;
  assign fifo_wr_data = fifo_wr_data_q;
  assign ovf_err      = ovf_err_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q        <= StIdle;
      gnt_q          <= 2'b00;
      last_q         <= 1'b1;
      remaining_q    <= '0;
      fifo_wr_en_q   <= 1'b0;
      fifo_wr_data_q <= '0;
      ovf_err_q      <= 1'b0;
    end else begin
      fifo_wr_en_q <= accept;
      if (accept) fifo_wr_data_q <= win_data;
      if (fifo_wr_en_q && full) ovf_err_q <= 1'b1;

      unique case (state_q)
        StIdle: begin
          if (room && (req != 2'b00)) begin
            state_q     <= StBurst;
            gnt_q       <= pick ? 2'b10 : 2'b01;
            last_q      <= pick;
            remaining_q <= RemW'(BURST_LEN);
          end
        end
        StBurst: begin
          if (accept) begin
            remaining_q <= remaining_q - RemW'(1);
            if (remaining_q == RemW'(1)) begin
              state_q <= StDone;
              gnt_q   <= 2'b00;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          gnt_q   <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: expected FIFO words are queued as they are
// offered and a separate monitor pops them whenever the DUT writes.
module tb_fifo_wr_arbiter;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [1:0] req, vld, gnt, rdy;
  logic [7:0] data0, data1, fifo_wr_data, wr_data_count;
  logic       burst_done, almost_full, full, wr_rst_busy, fifo_wr_en, ovf_err;

  int         checks = 0;
  int         errors = 0;
  int         n_writes = 0;
  logic [7:0] exp_q[$];

  fifo_wr_arbiter #(
    .DATA_W(8), .CNT_W(8), .DEPTH(256), .BURST_LEN(16), .SLACK(4)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .req(req), .vld(vld),
    .data0(data0), .data1(data1), .gnt(gnt), .rdy(rdy), .burst_done(burst_done),
    .wr_data_count(wr_data_count), .almost_full(almost_full), .full(full),
    .wr_rst_busy(wr_rst_busy), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .ovf_err(ovf_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every FIFO write must match the oldest queued word.
  always @(negedge sys_clk) begin
    if (!sys_rst && fifo_wr_en === 1'b1) begin
      n_writes++;
      if (exp_q.size() == 0) chk("unexpected_write", {24'd0, fifo_wr_data}, 32'hFFFF_FFFF);
      else chk("fifo_wr_data", {24'd0, fifo_wr_data}, {24'd0, exp_q.pop_front()});
    end
  end

  // Waits for a grant, feeds 16 words base..base+15, optionally stalls or resets mid-burst.
  task automatic do_burst(input logic [1:0] exp_gnt, input logic [7:0] base,
                          input int stall_after, input int stall_len, input int rst_at);
    int w;
    int k = 0;
    int stall_cnt = 0;
    int budget = 0;
    while (gnt === 2'b00 && budget < 50) begin
      @(negedge sys_clk);
      budget++;
    end
    chk("grant", {30'd0, gnt}, {30'd0, exp_gnt});
    if (gnt === 2'b00) return;
    w = gnt[1] ? 1 : 0;
    budget = 0;
    while (k < 16 && budget < 200) begin
      budget++;
      if (k == rst_at) begin
        sys_rst = 1'b1;
        vld[w] = 1'b1;
        #1;
        chk("rst_rdy_low", {30'd0, rdy}, 32'd0);
        chk("rst_wr_en_low", {31'd0, fifo_wr_en}, 32'd0);
        @(negedge sys_clk);
        chk("post_rst_gnt", {30'd0, gnt}, 32'd0);
        chk("post_rst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
        chk("post_rst_done", {31'd0, burst_done}, 32'd0);
        sys_rst = 1'b0;
        vld = 2'b00;
        exp_q.delete();
        return;
      end
      if (k == stall_after && stall_cnt < stall_len) begin
        almost_full = 1'b1;
        #1;
        chk("stall_rdy", {30'd0, rdy}, 32'd0);
        if (stall_cnt >= 1) chk("stall_wr_en", {31'd0, fifo_wr_en}, 32'd0);
        stall_cnt++;
        @(negedge sys_clk);
        continue;
      end
      almost_full = 1'b0;
      vld[w] = 1'b1;
      if (w == 1) data1 = base + 8'(k);
      else data0 = base + 8'(k);
      #1;
      if (rdy[w] === 1'b1) begin
        exp_q.push_back(base + 8'(k));
        k++;
      end
      @(negedge sys_clk);
    end
    vld = 2'b00;
    chk("burst_timeout", budget < 200 ? 32'd0 : 32'd1, 32'd0);
    chk("burst_done_pulse", {31'd0, burst_done}, 32'd1);
    chk("gnt_in_done", {30'd0, gnt}, 32'd0);
    @(negedge sys_clk);
    chk("burst_done_once", {31'd0, burst_done}, 32'd0);
  endtask

  logic [1:0] rr_gnt  [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [7:0] rr_base [4] = '{8'h00, 8'h10, 8'h20, 8'h30};

  initial begin
    sys_rst = 1'b1; req = 2'b00; vld = 2'b00; data0 = 8'h00; data1 = 8'h00;
    wr_data_count = 8'd0; almost_full = 1'b0; full = 1'b0; wr_rst_busy = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("rst_gnt", {30'd0, gnt}, 32'd0);
    chk("rst_rdy", {30'd0, rdy}, 32'd0);
    chk("rst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
    chk("rst_wr_data", {24'd0, fifo_wr_data}, 32'd0);
    chk("rst_ovf", {31'd0, ovf_err}, 32'd0);
    sys_rst = 1'b0;

    // Tie from reset goes to requester 0, then alternates.
    req = 2'b11;
    for (int i = 0; i < 4; i++) do_burst(rr_gnt[i], rr_base[i], -1, 0, -1);
    req = 2'b00;
    @(negedge sys_clk);
    chk("rr_writes", n_writes, 64);
    chk("rr_queue_empty", exp_q.size(), 0);

    // Room threshold: 237 blocks, 236 allows.
    wr_data_count = 8'd237;
    req = 2'b01;
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      chk("no_room_gnt", {30'd0, gnt}, 32'd0);
    end
    wr_data_count = 8'd236;
    @(negedge sys_clk);
    chk("room_gnt", {30'd0, gnt}, 32'd1);
    req = 2'b00;
    do_burst(2'b01, 8'h40, -1, 0, -1);
    wr_data_count = 8'd0;

    // almost_full stall after word 5 for 10 cycles.
    n_writes = 0;
    req = 2'b10;
    @(negedge sys_clk);
    req = 2'b00;
    do_burst(2'b10, 8'h50, 5, 10, -1);
    @(negedge sys_clk);
    chk("stall_writes", n_writes, 16);
    chk("stall_no_ovf", {31'd0, ovf_err}, 32'd0);

    // Reset while word 8 is offered; afterwards a tie grants requester 0 again.
    req = 2'b01;
    @(negedge sys_clk);
    req = 2'b00;
    do_burst(2'b01, 8'h60, -1, 0, 7);
    req = 2'b11;
    @(negedge sys_clk);
    req = 2'b00;
    do_burst(2'b01, 8'h70, -1, 0, -1);

    // Writes with full high set the sticky overflow flag.
    full = 1'b1;
    req = 2'b10;
    @(negedge sys_clk);
    req = 2'b00;
    do_burst(2'b10, 8'h80, -1, 0, -1);
    chk("ovf_set", {31'd0, ovf_err}, 32'd1);
    full = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("ovf_sticky", {31'd0, ovf_err}, 32'd1);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    chk("ovf_cleared", {31'd0, ovf_err}, 32'd0);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
